de_bad_trap_unit: RTL and testbench

//  Registered, handshaked successor to the combinational bad-opcode check. Sits

---
 rtl/de_bad_trap_unit.sv | 162 ++++++++++++++++
 tb/tb_de_bad_trap_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/de_bad_trap_unit.sv
// Registered fetch->decode stage: classifies 16/32/64-bit instructions, flags illegal
// opcodes against programmable masks, raises a trap. Optional counter: BAD_COUNT_EN.

module de_bad_classify (
    input  logic [63:0] i_inst,
    input  logic [63:0] i_bad_mask,
    input  logic [63:0] i_long_mask,
    output logic        o_bad
);
    logic       w_is16;
    logic       w_is32;
    logic [5:0] w_op;

    always_comb begin
        w_is16 = ~i_inst[63];
        w_is32 = (i_inst[63:62] == 2'b10);
        w_op   = i_inst[61:56];
        o_bad  = (w_is16 & (i_inst[62:60] == 3'b111)) |
                 (~w_is16 & i_bad_mask[w_op]) |
                 (w_is32 & i_long_mask[w_op]);
    end
endmodule

module de_bad_trap_unit #(
    parameter int          PC_W      = 64,
    parameter int          CNT_W     = 16,
    parameter logic [63:0] BAD_MASK  = 64'h0000_080C_0FF0_080C,
    // FSTAR=0x12, LUI=0x0D, JALI=0x30, JI=0x31 are only legal in 64-bit form
    parameter logic [63:0] LONG_MASK = 64'h0003_0000_0004_2000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inst_valid,
    output logic             o_inst_ready,
    input  logic [63:0]      i_inst_in,
    input  logic [PC_W-1:0]  i_pc_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [63:0]      o_out_inst,
    output logic [PC_W-1:0]  o_out_pc,
    output logic             o_out_bad,
    output logic             o_trap_req,
    input  logic             i_trap_ack,
    output logic [PC_W-1:0]  o_trap_pc,
    output logic [63:0]      o_trap_inst,
    input  logic             i_flush,
    input  logic             i_cfg_we,
    input  logic             i_cfg_sel,
    input  logic [5:0]       i_cfg_idx,
    input  logic             i_cfg_val,
    output logic [CNT_W-1:0] o_bad_count
);
    typedef enum logic {ST_RUN, ST_TRAP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [63:0]       r_bad_mask;
    logic [63:0]       r_long_mask;
    logic              r_out_valid;
    logic [63:0]       r_out_inst;
    logic [PC_W-1:0]   r_out_pc;
    logic              r_out_bad;
    logic              r_trap_req;
    logic [PC_W-1:0]   r_trap_pc;
    logic [63:0]       r_trap_inst;
    logic              w_inst_ready;
    logic              w_accept;
    logic              w_bad;
    logic              w_take_trap;

    de_bad_classify u_classify (
        .i_inst      (i_inst_in),
        .i_bad_mask  (r_bad_mask),
        .i_long_mask (r_long_mask),
        .o_bad       (w_bad)
    );

    always_comb begin
        w_inst_ready = (r_state == ST_RUN) & (~r_out_valid | i_out_ready);
        w_accept     = i_inst_valid & w_inst_ready;
        // A flushed accept is dropped entirely: no forward, no trap, no count
        w_take_trap  = w_accept & w_bad & ~i_flush;
        w_state_nxt  = r_state;
        if (i_flush) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (w_take_trap) w_state_nxt = ST_TRAP;
                ST_TRAP: if (i_trap_ack)  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_bad_mask  <= BAD_MASK;
            r_long_mask <= LONG_MASK;
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= '0;
            r_out_bad   <= 1'b0;
            r_trap_req  <= 1'b0;
            r_trap_pc   <= '0;
            r_trap_inst <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (i_cfg_we) begin
                if (i_cfg_sel) r_long_mask[i_cfg_idx] <= i_cfg_val;
                else           r_bad_mask[i_cfg_idx]  <= i_cfg_val;
            end

            if (i_flush) begin
                r_out_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_inst  <= i_inst_in;
                r_out_pc    <= i_pc_in;
                r_out_bad   <= w_bad;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (i_flush) begin
                r_trap_req <= 1'b0;
            end else if (w_take_trap) begin
                r_trap_req  <= 1'b1;
                r_trap_pc   <= i_pc_in;
                r_trap_inst <= i_inst_in;
            end else if ((r_state == ST_TRAP) && i_trap_ack) begin
                r_trap_req <= 1'b0;
            end
        end
    end

`ifdef BAD_COUNT_EN
    logic [CNT_W-1:0] r_bad_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bad_count <= '0;
        end else if (w_take_trap && !(&r_bad_count)) begin
            r_bad_count <= r_bad_count + 1'b1;
        end
    end

    assign o_bad_count = r_bad_count;
`else
    assign o_bad_count = '0;
`endif

    assign o_inst_ready = w_inst_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_inst   = r_out_inst;
    assign o_out_pc     = r_out_pc;
    assign o_out_bad    = r_out_bad;
    assign o_trap_req   = r_trap_req;
    assign o_trap_pc    = r_trap_pc;
    assign o_trap_inst  = r_trap_inst;
endmodule

// File: tb/tb_de_bad_trap_unit.sv
// Directed bench for de_bad_trap_unit: vector table plus handshake/trap/cfg sequences.

module tb_de_bad_trap_unit;
    localparam int PC_W  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             inst_valid;
    logic             inst_ready;
    logic [63:0]      inst_in;
    logic [PC_W-1:0]  pc_in;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_inst;
    logic [PC_W-1:0]  out_pc;
    logic             out_bad;
    logic             trap_req;
    logic             trap_ack;
    logic [PC_W-1:0]  trap_pc;
    logic [63:0]      trap_inst;
    logic             flush;
    logic             cfg_we;
    logic             cfg_sel;
    logic [5:0]       cfg_idx;
    logic             cfg_val;
    logic [CNT_W-1:0] bad_count;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    de_bad_trap_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_inst_valid(inst_valid), .o_inst_ready(inst_ready),
        .i_inst_in(inst_in), .i_pc_in(pc_in), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_inst(out_inst), .o_out_pc(out_pc), .o_out_bad(out_bad), .o_trap_req(trap_req),
        .i_trap_ack(trap_ack), .o_trap_pc(trap_pc), .o_trap_inst(trap_inst), .i_flush(flush),
        .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_idx(cfg_idx), .i_cfg_val(cfg_val),
        .o_bad_count(bad_count)
    );

    typedef struct {
        logic [63:0] inst;
        logic [63:0] pc;
        logic        exp_bad;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_cnt(input string nm);
`ifdef BAD_COUNT_EN
        check(nm, 64'(bad_count), 64'((exp_cnt > 15) ? 15 : exp_cnt));
`else
        check(nm, 64'(bad_count), 64'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_trap();
        @(negedge clk);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{64'h7000_0000_0000_0000, 64'h1000, 1'b1}; // 16-bit, top3 = 7
        vecs[1] = '{64'h6000_0000_0000_1234, 64'h1004, 1'b0}; // 16-bit, top3 = 6
        vecs[2] = '{64'h8200_0000_0000_0000, 64'h1008, 1'b1}; // 32-bit op 0x02
        vecs[3] = '{64'h8100_0000_0000_0000, 64'h100C, 1'b0}; // 32-bit op 0x01
        vecs[4] = '{64'h8D00_0000_0000_0000, 64'h1010, 1'b1}; // 32-bit LUI
        vecs[5] = '{64'hCD00_0000_0000_0000, 64'h1014, 1'b0}; // 64-bit LUI
        vecs[6] = '{64'hD400_0000_0000_0055, 64'h1018, 1'b1}; // 64-bit op 0x14
        vecs[7] = '{64'hF000_0000_0000_0000, 64'h101C, 1'b0}; // 64-bit JALI
        vecs[8] = '{64'hB000_0000_0000_0000, 64'h1020, 1'b1}; // 32-bit JALI
        vecs[9] = '{64'hEB00_0000_0000_0000, 64'h1024, 1'b1}; // 64-bit op 0x2B

        rst = 1'b1; inst_valid = 1'b0; inst_in = '0; pc_in = '0; out_ready = 1'b1;
        trap_ack = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_idx = '0; cfg_val = 1'b0;
        step(); step();
        check("rst out_valid", out_valid, 0);
        check("rst out_inst", out_inst, 0);
        check("rst out_pc", out_pc, 0);
        check("rst out_bad", out_bad, 0);
        check("rst trap_req", trap_req, 0);
        check("rst trap_pc", trap_pc, 0);
        check("rst trap_inst", trap_inst, 0);
        check_cnt("rst bad_count");
        @(negedge clk);
        rst = 1'b0;
        check("rst inst_ready", inst_ready, 1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            inst_valid = 1'b1; inst_in = vecs[i].inst; pc_in = vecs[i].pc;
            check($sformatf("v%0d inst_ready", i), inst_ready, 1);
            step();
            inst_valid = 1'b0;
            if (vecs[i].exp_bad) exp_cnt++;
            check($sformatf("v%0d out_valid", i), out_valid, 1);
            check($sformatf("v%0d out_inst", i), out_inst, vecs[i].inst);
            check($sformatf("v%0d out_pc", i), out_pc, vecs[i].pc);
            check($sformatf("v%0d out_bad", i), out_bad, vecs[i].exp_bad);
            check($sformatf("v%0d trap_req", i), trap_req, vecs[i].exp_bad);
            check_cnt($sformatf("v%0d bad_count", i));
            if (vecs[i].exp_bad) begin
                check($sformatf("v%0d trap_pc", i), trap_pc, vecs[i].pc);
                check($sformatf("v%0d trap_inst", i), trap_inst, vecs[i].inst);
                ack_trap();
                check($sformatf("v%0d trap_req ack", i), trap_req, 0);
            end else begin
                step();
            end
            check($sformatf("v%0d drained", i), out_valid, 0);
        end

        // Backpressure: hold for 3 cycles, then drain
        @(negedge clk);
        out_ready = 1'b0; inst_valid = 1'b1;
        inst_in = 64'h8100_0000_0000_00A1; pc_in = 64'h2000;
        step();
        check("bp first valid", out_valid, 1);
        @(negedge clk);
        inst_in = 64'hC000_0000_0000_00B2; pc_in = 64'h2008;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d inst_ready", k), inst_ready, 0);
            step();
            check($sformatf("bp%0d out_inst", k), out_inst, 64'h8100_0000_0000_00A1);
            check($sformatf("bp%0d out_pc", k), out_pc, 64'h2000);
            check($sformatf("bp%0d out_valid", k), out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp release ready", inst_ready, 1);
        step();
        inst_valid = 1'b0;
        check("bp second inst", out_inst, 64'hC000_0000_0000_00B2);
        check("bp second pc", out_pc, 64'h2008);
        step();
        check("bp drained", out_valid, 0);

        // Trap pending, flush and ack together; out_ready low so only flush clears valid
        @(negedge clk);
        out_ready = 1'b0; inst_valid = 1'b1; inst_in = 64'h7000_0000_0000_0001; pc_in = 64'h3000;
        step();
        inst_valid = 1'b0; exp_cnt++;
        check("fa trap_req", trap_req, 1);
        @(negedge clk);
        trap_ack = 1'b1; flush = 1'b1; inst_valid = 1'b1; inst_in = 64'h7000_0000_0000_0002;
        check("fa trap ready", inst_ready, 0);
        step();
        trap_ack = 1'b0; flush = 1'b0; inst_valid = 1'b0; out_ready = 1'b1;
        check("fa trap_req", trap_req, 0);
        check("fa out_valid", out_valid, 0);
        check("fa run ready", inst_ready, 1);
        check_cnt("fa bad_count");

        // Flush discards same-cycle bad accept
        @(negedge clk);
        inst_valid = 1'b1; flush = 1'b1; inst_in = 64'h7000_0000_0000_0003; pc_in = 64'h3010;
        step();
        inst_valid = 1'b0; flush = 1'b0;
        check("fl out_valid", out_valid, 0);
        check("fl trap_req", trap_req, 0);
        check("fl trap_pc", trap_pc, 64'h3000);
        check_cnt("fl bad_count");

        // cfg write: same-cycle accept uses old mask
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_idx = 6'h01; cfg_val = 1'b1;
        inst_valid = 1'b1; inst_in = 64'h8100_0000_0000_0010; pc_in = 64'h4000;
        step();
        cfg_we = 1'b0;
        check("cfg old mask", out_bad, 0);
        check("cfg old trap", trap_req, 0);
        @(negedge clk);
        inst_in = 64'h8100_0000_0000_0011; pc_in = 64'h4004;
        step();
        inst_valid = 1'b0; exp_cnt++;
        check("cfg new mask", out_bad, 1);
        check("cfg new trap", trap_req, 1);
        check("cfg trap_pc", trap_pc, 64'h4004);
        ack_trap();
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_idx = 6'h0D; cfg_val = 1'b0;
        step();
        cfg_we = 1'b0;
        @(negedge clk);
        inst_valid = 1'b1; inst_in = 64'h8D00_0000_0000_0000; pc_in = 64'h4010;
        step();
        inst_valid = 1'b0;
        check("cfg long cleared", out_bad, 0);
        check_cnt("cfg bad_count");
        step();

        // Reset mid-trap reloads masks
        @(negedge clk);
        inst_valid = 1'b1; inst_in = 64'h7000_0000_0000_0004; pc_in = 64'h5000;
        step();
        inst_valid = 1'b0; exp_cnt++;
        check("rt trap_req", trap_req, 1);
        @(negedge clk);
        rst = 1'b1;
        step();
        exp_cnt = 0;
        check("rt trap_req", trap_req, 0);
        check("rt trap_pc", trap_pc, 0);
        check("rt trap_inst", trap_inst, 0);
        check("rt out_valid", out_valid, 0);
        check("rt out_inst", out_inst, 0);
        check_cnt("rt bad_count");
        @(negedge clk);
        rst = 1'b0; inst_valid = 1'b1; inst_in = 64'h8100_0000_0000_0000; pc_in = 64'h5008;
        step();
        check("rt bad_mask reload", out_bad, 0);
        @(negedge clk);
        inst_in = 64'h8D00_0000_0000_0000; pc_in = 64'h500C;
        step();
        inst_valid = 1'b0; exp_cnt++;
        check("rt long_mask reload", out_bad, 1);
        ack_trap();

`ifdef BAD_COUNT_EN
        // Drive past saturation of the narrow bench counter
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            inst_valid = 1'b1; inst_in = 64'h7000_0000_0000_0000; pc_in = 64'h6000;
            step();
            inst_valid = 1'b0; exp_cnt++;
            ack_trap();
        end
        check("sat bad_count", 64'(bad_count), 64'd15);
`endif
        check_cnt("final bad_count");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
